// File: rtl/imm_decode_pipe_pkg.sv
// imm_pkg: shared types for the immediate-decode stage.
//   fmt_e    - immediate format code carried on out_fmt
//   OP_*     - major opcodes recognised by the decoder
//   bundle_t - decoded output bundle; imm/target are sized for the widest
//              datapath and the pipe keeps only the low XLEN bits
package imm_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    fmt_e                fmt;
    logic [XLEN_MAX-1:0] target;
    logic                illegal;
  } bundle_t;

endpackage

// File: rtl/imm_decode_pipe_extract.sv
// imm_extract: combinational immediate decoder.
//   instr  - raw 32-bit instruction word
//   pc     - PC of instr (XLEN bits)
//   bundle - decoded immediate, format, PC-relative target, illegal flag
// Parameters: XLEN (32/64), EN_CSR_IMM (decode CSR zimm when 1).
import imm_pkg::*;

module imm_extract #(
  parameter int unsigned XLEN       = 32,
  parameter bit          EN_CSR_IMM = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output bundle_t         bundle
);

  logic [6:0]      opcode;
  fmt_e            fmt;
  logic            illegal;
  logic            use_pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;

  assign opcode = instr[6:0];

  // Opcode compare covers instr[1:0] != 2'b11 too: every listed opcode ends in 11.
  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    use_pc  = 1'b0;
    case (opcode)
      OP_IMM, LOAD, JALR: fmt = FMT_I;
      OP_IMM_32: begin
        if (XLEN == 64) fmt = FMT_I;
        else            illegal = 1'b1;
      end
      STORE:  fmt = FMT_S;
      BRANCH: begin
        fmt    = FMT_B;
        use_pc = 1'b1;
      end
      LUI:    fmt = FMT_U;
      AUIPC:  begin
        fmt    = FMT_U;
        use_pc = 1'b1;
      end
      JAL:    begin
        fmt    = FMT_J;
        use_pc = 1'b1;
      end
      OP, MISC_MEM: fmt = FMT_NONE;
      OP_32: begin
        if (XLEN != 64) illegal = 1'b1;
      end
      SYSTEM: begin
        if (instr[14] && EN_CSR_IMM) fmt = FMT_Z;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = XLEN'($signed(instr[31:20]));
      FMT_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U: imm = XLEN'($signed({instr[31:12], 12'h000}));
      FMT_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FMT_Z: imm = XLEN'(instr[19:15]);
      default: imm = '0;
    endcase
  end

  assign target = use_pc ? (pc + imm) : '0;

  assign bundle.imm     = XLEN_MAX'(imm);
  assign bundle.fmt     = fmt;
  assign bundle.target  = XLEN_MAX'(target);
  assign bundle.illegal = illegal;

endmodule

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: registered immediate-decode stage with a 2-entry skid.
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - upstream handshake
//   in_instr, in_pc               - instruction word and its PC
//   out_valid/out_ready           - downstream handshake
//   out_imm, out_fmt, out_target  - decoded immediate, format, PC-relative target
//   out_illegal                   - unrecognised opcode
import imm_pkg::*;

module imm_decode_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter bit          EN_CSR_IMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  bundle_t dec;
  bundle_t main_q;
  bundle_t skid_q;
  logic    skid_valid;
  logic    in_fire;
  logic    main_open;

  imm_extract #(
    .XLEN       (XLEN),
    .EN_CSR_IMM (EN_CSR_IMM)
  ) u_extract (
    .instr  (in_instr),
    .pc     (in_pc),
    .bundle (dec)
  );

  assign in_ready  = !skid_valid && !rst;
  assign in_fire   = in_valid && in_ready;
  assign main_open = !out_valid || out_ready;

  // Skid has priority when the main register opens; in_ready is already low
  // whenever the skid is occupied, so no input can be lost on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (main_open) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_q    <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_fmt     = main_q.fmt;
  assign out_target  = main_q.target[XLEN-1:0];
  assign out_illegal = main_q.illegal;

  generate
    if (XLEN < XLEN_MAX) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^{main_q.imm[XLEN_MAX-1:XLEN], main_q.target[XLEN_MAX-1:XLEN]};
    end
  endgenerate

endmodule

// File: tb/tb_imm_decode_pipe.sv
module tb_imm_decode_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_target;
  logic        out_illegal;

  logic        in_valid_64;
  logic        in_ready_64;
  logic [31:0] in_instr_64;
  logic [63:0] in_pc_64;
  logic        out_valid_64;
  logic        out_ready_64;
  logic [63:0] out_imm_64;
  logic [2:0]  out_fmt_64;
  logic [63:0] out_target_64;
  logic        out_illegal_64;

  int total;
  int bad;

  imm_decode_pipe #(.XLEN(32), .EN_CSR_IMM(1'b1)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_decode_pipe #(.XLEN(64), .EN_CSR_IMM(1'b0)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_64), .in_ready(in_ready_64), .in_instr(in_instr_64), .in_pc(in_pc_64),
    .out_valid(out_valid_64), .out_ready(out_ready_64), .out_imm(out_imm_64),
    .out_fmt(out_fmt_64), .out_target(out_target_64), .out_illegal(out_illegal_64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (out_valid !== 1'b0)   begin $display("FAIL rst_valid got=%b want=0", out_valid); bad++; end
    total++; if (out_imm !== 32'h0)    begin $display("FAIL rst_imm got=%h want=0", out_imm); bad++; end
    total++; if (out_fmt !== 3'd0)     begin $display("FAIL rst_fmt got=%0d want=0", out_fmt); bad++; end
    total++; if (out_target !== 32'h0) begin $display("FAIL rst_target got=%h want=0", out_target); bad++; end
    total++; if (out_illegal !== 1'b0) begin $display("FAIL rst_illegal got=%b want=0", out_illegal); bad++; end
    total++; if (in_ready !== 1'b0)    begin $display("FAIL rst_in_ready_low got=%b want=0", in_ready); bad++; end
    total++; if (out_valid_64 !== 1'b0) begin $display("FAIL rst_valid64 got=%b want=0", out_valid_64); bad++; end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1)    begin $display("FAIL rst_in_ready_high got=%b want=1", in_ready); bad++; end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    in_pc     = 32'h0;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1)          begin $display("FAIL addi_valid got=%b want=1", out_valid); bad++; end
    total++; if (out_imm !== 32'hFFFFFFFF)    begin $display("FAIL addi_imm got=%h want=ffffffff", out_imm); bad++; end
    total++; if (out_fmt !== 3'd1)            begin $display("FAIL addi_fmt got=%0d want=1", out_fmt); bad++; end
    total++; if (out_illegal !== 1'b0)        begin $display("FAIL addi_illegal got=%b want=0", out_illegal); bad++; end
    total++; if (out_target !== 32'h0)        begin $display("FAIL addi_target got=%h want=0", out_target); bad++; end
  endtask

  task automatic test_branch();
    in_valid = 1'b1;
    in_instr = 32'hFE000EE3;
    in_pc    = 32'h00001000;
    step();
    total++; if (out_imm !== 32'hFFFFFFFC)    begin $display("FAIL beq_imm got=%h want=fffffffc", out_imm); bad++; end
    total++; if (out_fmt !== 3'd3)            begin $display("FAIL beq_fmt got=%0d want=3", out_fmt); bad++; end
    total++; if (out_target !== 32'h00000FFC) begin $display("FAIL beq_target got=%h want=00000ffc", out_target); bad++; end
    in_pc = 32'h0;
    step();
    total++; if (out_target !== 32'hFFFFFFFC) begin $display("FAIL beq_wrap got=%h want=fffffffc", out_target); bad++; end
    in_instr = 32'h00001097;
    in_pc    = 32'h00000100;
    step();
    in_valid = 1'b0;
    total++; if (out_imm !== 32'h00001000)    begin $display("FAIL auipc_imm got=%h want=00001000", out_imm); bad++; end
    total++; if (out_fmt !== 3'd4)            begin $display("FAIL auipc_fmt got=%0d want=4", out_fmt); bad++; end
    total++; if (out_target !== 32'h00001100) begin $display("FAIL auipc_target got=%h want=00001100", out_target); bad++; end
    in_instr = 32'h00208033;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_fmt !== 3'd0 || out_illegal !== 1'b0 || out_imm !== 32'h0)
      begin $display("FAIL add_none got=fmt%0d/ill%b/%h want=fmt0/ill0/0", out_fmt, out_illegal, out_imm); bad++; end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_instr = 32'h123452B7;
    in_pc    = 32'h00000400;
    step();
    total++; if (out_imm !== 32'h12345000)    begin $display("FAIL lui_imm got=%h want=12345000", out_imm); bad++; end
    total++; if (out_fmt !== 3'd4)            begin $display("FAIL lui_fmt got=%0d want=4", out_fmt); bad++; end
    total++; if (out_target !== 32'h0)        begin $display("FAIL lui_target got=%h want=0", out_target); bad++; end
    in_instr = 32'h3002D073;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1)          begin $display("FAIL csr_valid got=%b want=1", out_valid); bad++; end
    total++; if (out_imm !== 32'h5)           begin $display("FAIL csr_imm got=%h want=5", out_imm); bad++; end
    total++; if (out_fmt !== 3'd6)            begin $display("FAIL csr_fmt got=%0d want=6", out_fmt); bad++; end
    step();
    total++; if (out_valid !== 1'b0)          begin $display("FAIL b2b_drain got=%b want=0", out_valid); bad++; end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    total++; if (in_ready !== 1'b1)           begin $display("FAIL bp_ready0 got=%b want=1", in_ready); bad++; end
    step();
    total++; if (out_imm !== 32'hFFFFFFFF || out_valid !== 1'b1)
      begin $display("FAIL bp_first got=%b/%h want=1/ffffffff", out_valid, out_imm); bad++; end
    total++; if (in_ready !== 1'b1)           begin $display("FAIL bp_ready1 got=%b want=1", in_ready); bad++; end
    in_instr = 32'h00500113;
    step();
    total++; if (in_ready !== 1'b0)           begin $display("FAIL bp_ready2 got=%b want=0", in_ready); bad++; end
    total++; if (out_imm !== 32'hFFFFFFFF)    begin $display("FAIL bp_hold1 got=%h want=ffffffff", out_imm); bad++; end
    in_instr = 32'h00700193;
    step();
    total++; if (in_ready !== 1'b0)           begin $display("FAIL bp_ready3 got=%b want=0", in_ready); bad++; end
    total++; if (out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd1 || out_valid !== 1'b1)
      begin $display("FAIL bp_hold2 got=%b/%h/%0d want=1/ffffffff/1", out_valid, out_imm, out_fmt); bad++; end
    out_ready = 1'b1;
    step();
    total++; if (out_imm !== 32'h5 || out_valid !== 1'b1)
      begin $display("FAIL bp_second got=%b/%h want=1/5", out_valid, out_imm); bad++; end
    total++; if (in_ready !== 1'b1)           begin $display("FAIL bp_reopen got=%b want=1", in_ready); bad++; end
    step();
    in_valid = 1'b0;
    total++; if (out_imm !== 32'h7 || out_valid !== 1'b1)
      begin $display("FAIL bp_third got=%b/%h want=1/7", out_valid, out_imm); bad++; end
    step();
    total++; if (out_valid !== 1'b0)          begin $display("FAIL bp_drain got=%b want=0", out_valid); bad++; end
  endtask

  task automatic test_illegal32();
    in_valid = 1'b1;
    in_instr = 32'h00000000;
    in_pc    = 32'h00000200;
    step();
    total++; if (out_illegal !== 1'b1 || out_imm !== 32'h0 || out_fmt !== 3'd0 || out_target !== 32'h0)
      begin $display("FAIL ill_zero got=ill%b/%h/fmt%0d/%h want=ill1/0/fmt0/0", out_illegal, out_imm, out_fmt, out_target); bad++; end
    total++; if (out_valid !== 1'b1)          begin $display("FAIL ill_propagates got=%b want=1", out_valid); bad++; end
    in_instr = 32'h0010009B;
    step();
    in_valid = 1'b0;
    total++; if (out_illegal !== 1'b1 || out_imm !== 32'h0 || out_fmt !== 3'd0)
      begin $display("FAIL ill_addiw32 got=ill%b/%h/fmt%0d want=ill1/0/fmt0", out_illegal, out_imm, out_fmt); bad++; end
    step();
  endtask

  task automatic test_rv64();
    out_ready_64 = 1'b1;
    in_valid_64  = 1'b1;
    in_instr_64  = 32'hFFFFF06F;
    in_pc_64     = 64'h0;
    step();
    total++; if (out_imm_64 !== 64'hFFFFFFFFFFFFFFFE)    begin $display("FAIL jal64_imm got=%h want=fffffffffffffffe", out_imm_64); bad++; end
    total++; if (out_target_64 !== 64'hFFFFFFFFFFFFFFFE) begin $display("FAIL jal64_target got=%h want=fffffffffffffffe", out_target_64); bad++; end
    total++; if (out_fmt_64 !== 3'd5)                    begin $display("FAIL jal64_fmt got=%0d want=5", out_fmt_64); bad++; end
    in_instr_64 = 32'h0010009B;
    step();
    total++; if (out_fmt_64 !== 3'd1 || out_imm_64 !== 64'h1 || out_illegal_64 !== 1'b0)
      begin $display("FAIL addiw64 got=fmt%0d/%h/ill%b want=fmt1/1/ill0", out_fmt_64, out_imm_64, out_illegal_64); bad++; end
    in_instr_64 = 32'h800000B7;
    step();
    total++; if (out_imm_64 !== 64'hFFFFFFFF80000000 || out_target_64 !== 64'h0)
      begin $display("FAIL lui64 got=%h/%h want=ffffffff80000000/0", out_imm_64, out_target_64); bad++; end
    in_instr_64 = 32'h3002D073;
    step();
    in_valid_64 = 1'b0;
    total++; if (out_fmt_64 !== 3'd0 || out_imm_64 !== 64'h0 || out_illegal_64 !== 1'b0)
      begin $display("FAIL csr_noimm got=fmt%0d/%h/ill%b want=fmt0/0/ill0", out_fmt_64, out_imm_64, out_illegal_64); bad++; end
    step();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500113;
    step();
    in_instr  = 32'h00700193;
    step();
    in_valid  = 1'b0;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
      begin $display("FAIL mid_full got=rdy%b/val%b want=rdy0/val1", in_ready, out_valid); bad++; end
    rst = 1'b1;
    step();
    total++; if (out_valid !== 1'b0)          begin $display("FAIL mid_rst_valid got=%b want=0", out_valid); bad++; end
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1)           begin $display("FAIL mid_rst_ready got=%b want=1", in_ready); bad++; end
    step();
    total++; if (out_valid !== 1'b0)          begin $display("FAIL mid_no_ghost got=%b want=0", out_valid); bad++; end
    in_valid = 1'b1;
    in_instr = 32'hFFF00093;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF)
      begin $display("FAIL mid_resume got=%b/%h want=1/ffffffff", out_valid, out_imm); bad++; end
    step();
    total++; if (out_valid !== 1'b0)          begin $display("FAIL mid_resume_drain got=%b want=0", out_valid); bad++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_instr     = 32'h0;
    in_pc        = 32'h0;
    out_ready    = 1'b1;
    in_valid_64  = 1'b0;
    in_instr_64  = 32'h0;
    in_pc_64     = 64'h0;
    out_ready_64 = 1'b1;
    test_reset();
    test_addi();
    test_branch();
    test_back_to_back();
    test_backpressure();
    test_illegal32();
    test_rv64();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Registered, parametrised immediate-decode stage for the RV32/RV64 core, sitting between fetch and the register-read/execute stage. It accepts one instruction per cycle with its PC and emits the sign-extended immediate, the immediate format, the PC-relative target, and an illegal-opcode flag. A valid/ready handshake with a 2-entry skid buffer allows full-throughput operation under downstream backpressure.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 and 64 are legal.
- EN_CSR_IMM, 1, when 1, decodes the CSR zimm format; when 0, CSR-immediate instructions report fmt NONE.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts this cycle.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- out_target  out  XLEN  in_pc + out_imm for fmt B/J/U-AUIPC; 0 otherwise.
- out_illegal  out  1  unrecognised opcode.

## Operation
- Formats by opcode:
  - I: 0010011, 0000011, 1100111, plus 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Z: 1110011 with funct3[2]=1. Immediate is instr[19:15], zero-extended.
  - NONE, legal: 0110011, 0001111, 1110011 with funct3[2]=0, plus 0111011 when XLEN=64.
- Sign extension: I/S/B/J immediates sign-extend from instr[31] to XLEN. U places instr[31:12] at bits 31:12 and sign-extends to XLEN.
- out_target uses XLEN-bit modulo arithmetic; wrap-around is silent.
  - B/J: target = pc + imm.
  - AUIPC: target = pc + imm.
  - LUI and all other formats: target = 0.
- Illegal: instr[1:0] != 2'b11, or any opcode not listed above (including the RV64-only opcodes when XLEN=32). On illegal: out_imm=0, out_fmt=NONE, out_target=0, out_illegal=1.
- The instruction still propagates on illegal; the stage never drops a transfer.
- Transfers: a transfer occurs on each edge where valid&&ready, on both the input and output sides.
- Storage: main output register plus one skid register.
  - in_ready = !skid_valid.
  - When the output is stalled (out_valid && !out_ready) and an input is accepted, the decoded bundle goes to the skid register.
  - When the output drains, the skid register moves to the output register first.
- Order is strictly FIFO; at most 2 bundles are in flight.

## Timing
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_target=0, out_illegal=0, skid empty.
- in_ready is 0 while rst=1 and 1 on the first cycle after rst deasserts.
- Reset mid-operation discards both entries at the next edge; no partial bundle ever appears.
- Simultaneous output drain and input accept with the skid empty: the output register loads the new bundle, with no bubble.
- Simultaneous output drain and input accept with the skid full: cannot happen, because in_ready=0 when the skid is full.
- The skid refills the output in the same edge that drains it.
- Output stability: while out_valid=1 and out_ready=0, every out_* signal holds stable.

## Structure
- Package imm_pkg holds:
  - the fmt enum (3-bit);
  - opcode localparams (OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP, MISC_MEM, SYSTEM, OP_IMM_32, OP_32);
  - the output bundle struct (imm, fmt, target, illegal).
- Sub-module imm_extract: purely combinational, parameterised by XLEN and EN_CSR_IMM. Maps instr and pc to the bundle.
- The top module holds only the handshake, the main register, and the skid register.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1), out_ready=1: after 1 cycle, out_imm=0xFFFFFFFF, fmt=I, illegal=0.
- pc=0x00001000, 0xFE000EE3 (beq -4): out_imm=0xFFFFFFFC, fmt=B, out_target=0x00000FFC.
- Back-to-back stream:
  - Send 0x123452B7 (lui) followed by 0x3002D073 (csrrwi zimm=5).
  - Expected: imm=0x12345000, fmt=U, target=0; then imm=5, fmt=Z.
- Backpressure:
  - Hold out_ready=0 for 3 cycles while offering 3 instructions.
  - Expected: in_ready falls after 2 accepts; outputs stay stable.
  - On release, all 3 emerge in order with no loss or duplication.
- 0x00000000 and opcode 0011011 under XLEN=32: illegal=1, imm=0. Under XLEN=64, 0011011 decodes as fmt=I.
- XLEN=64, pc=0x0, jal -2 (0xFFFFF06F): imm=0xFFFFFFFFFFFFFFFE, target wraps to 0xFFFFFFFFFFFFFFFE.
- Assert rst with both entries full: out_valid=0 at the next edge, then normal flow resumes.
